// File: rtl/cont_regressivo_param_if.sv
// Control/status bundle for the irrigation down-counter: load/enable/abort/mode
// requests in, count value and end-of-count status out.
interface cont_regressivo_param_if #(
   parameter int WIDTH = 4
) ();
   logic             load;
   logic [WIDTH-1:0] valor;
   logic             en;
   logic             para;
   logic             auto;
   logic [WIDTH-1:0] q;
   logic             zero;
   logic             fim;
   logic             ativo;

   modport master (
      output load, valor, en, para, auto,
      input  q, zero, fim, ativo
   );

   modport slave (
      input  load, valor, en, para, auto,
      output q, zero, fim, ativo
   );
endinterface

// File: rtl/cont_regressivo_param.sv
// Programmable down-counter/timer: counts a loaded value down to 0, one step per
// PRESCALE enabled clocks, with pause, abort, one-shot/auto-reload and end pulse.
//
// state | meaning
// IDLE  | Q held at 0, waiting for a load
// RUN   | counting (prescaler advances while enabled)
// HOLD  | paused, Q and prescaler frozen until enable returns
module cont_regressivo_param #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input logic                     i_clk,
   input logic                     i_rst,
   cont_regressivo_param_if.slave  bus
);

   localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_reload;
   logic [PW-1:0]    r_pre;
   logic             r_fim;
   logic             r_ativo;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_q      <= '0;
         r_reload <= '0;
         r_pre    <= '0;
         r_fim    <= 1'b0;
         r_ativo  <= 1'b0;
      end else begin
         r_fim <= 1'b0;
         if (bus.load) begin
            r_q      <= bus.valor;
            r_reload <= bus.valor;
            r_pre    <= '0;
            if (bus.valor != '0) begin
               r_state <= RUN;
               r_ativo <= 1'b1;
            end else begin
               r_state <= IDLE;
               r_ativo <= 1'b0;
            end
         end else if (bus.para) begin
            r_q     <= '0;
            r_pre   <= '0;
            r_state <= IDLE;
            r_ativo <= 1'b0;
         end else begin
            case (r_state)
               IDLE: ;
               HOLD: begin
                  if (bus.en) begin
                     r_state <= RUN;
                     r_ativo <= 1'b1;
                  end
               end
               RUN: begin
                  if (!bus.en) begin
                     r_state <= HOLD;
                     r_ativo <= 1'b0;
                  end else if (r_pre != PRE_LAST) begin
                     r_pre <= r_pre + PW'(1);
                  end else begin
                     r_pre <= '0;
                     if (r_q > ONE) begin
                        r_q <= r_q - ONE;
                     end else if (r_q == ONE) begin
                        r_q   <= '0;
                        r_fim <= 1'b1;
                        if (!bus.auto) begin
                           r_state <= IDLE;
                           r_ativo <= 1'b0;
                        end
                     end else if (bus.auto && r_reload != '0) begin
                        // Q==0 tick in auto mode closes the N..0 period
                        r_q <= r_reload;
                     end else begin
                        r_state <= IDLE;
                        r_ativo <= 1'b0;
                     end
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_ativo <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.q     = r_q;
   assign bus.zero  = (r_q == '0);
   assign bus.fim   = r_fim;
   assign bus.ativo = r_ativo;

endmodule
